tennis_score_fsm: RTL

- Point-scoring engine for one tennis game; the source of the p0/p1/squash score bus read by the seven-segment score display driver.
- Synchronizes and debounces the raw point-won buttons for both players, then edge-detects them.
- Runs a no-ad game state machine and presents scores as 2-bit codes: 0=0, 1=15, 2=30, 3=40.
- On a game win, asserts squash and reports the winner on p0 until a new game starts.

---
 rtl/tennis_score_fsm.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tennis_score_fsm.sv
// Point-scoring engine for one no-ad tennis game: debounced buttons feed a
// PLAY/WIN state machine that drives the p0/p1/squash score bus and game tallies.
module tennis_score_fsm #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned WIN_HOLD  = 200000000,
  parameter int unsigned CNT_W     = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_p0,
  input  logic       btn_p1,
  input  logic       btn_new,
  output logic [1:0] p0,
  output logic [1:0] p1,
  output logic       squash,
  output logic [2:0] games0,
  output logic [2:0] games1
);

  typedef enum logic {
    S_PLAY = 1'b0,
    S_WIN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(WIN_HOLD - 1);

  // Button lanes: bit 0 = player 0, bit 1 = player 1, bit 2 = new game.
  logic [2:0]       raw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       db_q;
  logic [2:0]       db_d;
  logic [2:0]       db_prev_q;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [CNT_W-1:0] db_cnt_d [3];
  logic [2:0]       pulse;
  logic             pt0;
  logic             pt1;
  logic             ng;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       p0_q;
  logic [1:0]       p0_d;
  logic [1:0]       p1_q;
  logic [1:0]       p1_d;
  logic [2:0]       games0_q;
  logic [2:0]       games0_d;
  logic [2:0]       games1_q;
  logic [2:0]       games1_d;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;

  assign raw = {btn_new, btn_p1, btn_p0};

  // A level change is accepted only after DB_CYCLES consecutive mismatching
  // cycles; any cycle where the synchronized input agrees restarts the count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign pulse = db_q & ~db_prev_q;
  assign pt0   = pulse[0];
  assign pt1   = pulse[1];
  assign ng    = pulse[2];

  always_comb begin
    state_d  = state_q;
    p0_d     = p0_q;
    p1_d     = p1_q;
    games0_d = games0_q;
    games1_d = games1_q;
    hold_d   = hold_q;
    case (state_q)
      S_PLAY: begin
        if (ng) begin
          p0_d = 2'd0;
          p1_d = 2'd0;
        end else if (pt0 && pt1) begin
          // Simultaneous points cancel out.
        end else if (pt0) begin
          if (p0_q != 2'd3) begin
            p0_d = p0_q + 2'd1;
          end else begin
            state_d  = S_WIN;
            p0_d     = 2'b01;
            p1_d     = 2'd0;
            hold_d   = '0;
            games0_d = (games0_q != 3'd7) ? games0_q + 3'd1 : games0_q;
          end
        end else if (pt1) begin
          if (p1_q != 2'd3) begin
            p1_d = p1_q + 2'd1;
          end else begin
            state_d  = S_WIN;
            p0_d     = 2'b10;
            p1_d     = 2'd0;
            hold_d   = '0;
            games1_d = (games1_q != 3'd7) ? games1_q + 3'd1 : games1_q;
          end
        end
      end
      S_WIN: begin
        // New game and hold expiry coinciding still make one transition.
        if (ng || (hold_q == HOLD_LAST)) begin
          state_d = S_PLAY;
          p0_d    = 2'd0;
          p1_d    = 2'd0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = S_PLAY;
        p0_d    = 2'd0;
        p1_d    = 2'd0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_PLAY;
      p0_q     <= 2'd0;
      p1_q     <= 2'd0;
      games0_q <= 3'd0;
      games1_q <= 3'd0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      p0_q     <= p0_d;
      p1_q     <= p1_d;
      games0_q <= games0_d;
      games1_q <= games1_d;
      hold_q   <= hold_d;
    end
  end

  assign p0     = p0_q;
  assign p1     = p1_q;
  assign squash = (state_q == S_WIN);
  assign games0 = games0_q;
  assign games1 = games1_q;

endmodule
